// File: rtl/req_enc_pkg.sv
// Shared types and sizing helpers for the request encoder.
// Imported by the priority encoder and by the top level.
package req_enc_pkg;

    localparam int N_REQ_DEFAULT = 4;

    // Index width for n request lines.
    // A single line still needs one index bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        EMPTY,
        FULL
    } slot_state_t;

endpackage

// File: rtl/req_encoder_4x2_prio_enc.sv
// Combinational priority encoder: the highest set bit of vec wins.
// When vec is zero, all outputs are zero.
module prio_enc_n
    import req_enc_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic [N_REQ-1:0]         vec,
    output logic [idx_w(N_REQ)-1:0] idx,
    output logic [N_REQ-1:0]         onehot,
    output logic                     any
);

    localparam int IDX_W = idx_w(N_REQ);

    always_comb begin
        idx    = '0;
        onehot = '0;
        any    = |vec;
        // Ascending scan, so the last (highest) set bit overwrites lower ones.
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/req_encoder_4x2.sv
// Sequential priority encoder. Request events are latched into a pending
// register and emitted highest-index-first through a valid/ready output slot.
module req_encoder_4x2
    import req_enc_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req_in,
    output logic [idx_w(N_REQ)-1:0] idx_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [N_REQ-1:0]         pending_out,
    output logic                     overflow_out
);

    localparam int IDX_W = idx_w(N_REQ);

    // Output handshake: a transfer happens at a rising edge where
    // valid_out & ready_in. idx_out is stable while valid_out is high
    // and ready_in is low.
    slot_state_t      state, state_next;
    logic [N_REQ-1:0] pending, pending_next;
    logic [IDX_W-1:0] idx_next;
    logic             overflow_next;

    logic [IDX_W-1:0] prio_idx;
    logic [N_REQ-1:0] prio_onehot;
    logic             prio_any;

    logic             load;
    logic [N_REQ-1:0] load_mask;
    logic [N_REQ-1:0] capture;

    prio_enc_n #(
        .N_REQ (N_REQ)
    ) u_prio (
        .vec    (pending),
        .idx    (prio_idx),
        .onehot (prio_onehot),
        .any    (prio_any)
    );

    always_comb begin
        state_next    = state;
        load          = 1'b0;
        case (state)
            EMPTY: begin
                if (prio_any) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (ready_in) begin
                    load       = prio_any;
                    state_next = prio_any ? FULL : EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase

        load_mask     = load ? prio_onehot : '0;
        capture       = en ? req_in : '0;
        // A newly captured bit re-arms pending even if it is being loaded now.
        pending_next  = (pending & ~load_mask) | capture;
        overflow_next = |(capture & pending & ~load_mask);
        idx_next      = load ? prio_idx : idx_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            pending      <= '0;
            idx_out      <= '0;
            overflow_out <= 1'b0;
        end else begin
            state        <= state_next;
            pending      <= pending_next;
            idx_out      <= idx_next;
            overflow_out <= overflow_next;
        end
    end

    assign valid_out   = (state == FULL);
    assign pending_out = pending;

endmodule

// File: doc/req_encoder_4x2.md
Name: req_encoder_4x2

Overview:
- Sequential priority encoder; the opposite direction of the team's 2x4 one-hot decoder.
- Latches request events on N_REQ lines into a pending register.
- Emits the binary index of the highest-priority pending request through a valid/ready output slot.
- Sits in front of the decoder and index-driven logic, e.g. interrupt or event sources converted to an index stream.

Parameters:
- N_REQ, 4, number of request lines; legal range 2..16.
- IDX_W, $clog2(N_REQ), index width; derived, must not be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  request capture enable; when 0, req_in is ignored.
- req_in  input  N_REQ  request events, one bit per source, sampled every edge while en=1.
- idx_out  output  IDX_W  encoded index of the granted request.
- valid_out  output  1  idx_out holds a valid index.
- ready_in  input  1  consumer accepts idx_out when valid_out & ready_in.
- pending_out  output  N_REQ  requests captured but not yet loaded into the output slot.
- overflow_out  output  1  one-cycle pulse: an incoming request merged into an already-pending bit.

Behaviour:
- Reset (rst_n=0, asynchronous): idx_out=0, valid_out=0, pending_out=0, overflow_out=0, FSM=EMPTY. Reset mid-operation discards all pending and held indices; no output is produced for them after release.
- Priority: the highest set index wins, so bit N_REQ-1 has top priority. This matches the decoder mapping (e.g. index 3 ↔ 4'b1000).
- FSM for the output slot:
  - EMPTY: valid_out=0. At an edge where pending≠0, load idx_out=prio(pending), set valid_out=1 and go to FULL.
  - FULL: valid_out=1 and idx_out is held stable. At an edge with ready_in=1:
    - if pending≠0, reload idx_out=prio(pending) and stay FULL (back-to-back, one index per cycle);
    - otherwise valid_out=0 and go to EMPTY.
  - FULL with ready_in=0: no change.
- The load decision uses the registered pending value only. Same-edge req_in is never visible to the load.
- Pending update each edge: pending_next = (pending & ~load_mask) | (en ? req_in : 0).
  - load_mask is the one-hot of the index loaded at this edge; it is 0 when nothing loads.
  - Set wins over clear: a req_in bit equal to the index being loaded re-arms pending as a new event.
- Latency: req_in asserted before edge E0 appears in pending_out after E0. With the slot free, valid_out/idx_out are set after E1 (2 cycles).
- overflow_out is 1 for the cycle after an edge where en=1, req_in[i]=1, pending[i]=1 and bit i is not loaded at that edge. The duplicate is merged, not queued.
  - A request for the index currently held in idx_out (already removed from pending) is not an overflow.
- en=0: no capture and no overflow. Pending entries still drain normally.
- ready_in while valid_out=0 has no effect.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package req_enc_pkg holds:
  - N_REQ_DEFAULT=4;
  - the function for IDX_W;
  - typedef enum logic {EMPTY, FULL} slot_state_t.
- Sub-module prio_enc_n (combinational), parameter N_REQ:
  - input vec [N_REQ-1:0];
  - outputs idx [IDX_W-1:0], onehot [N_REQ-1:0], any.
  - idx=0, onehot=0, any=0 when vec=0.
- The top level instantiates one prio_enc_n on pending.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle with valid_out=1 and pending=4'b0110 → all outputs 0 immediately. After release with req_in=0, no valid_out for 10 cycles.
- Single request: en=1, req_in=4'b0100 for one cycle, ready_in=1 → pending_out=4'b0100 after E0, then valid_out=1 with idx_out=2 after E1, then pending_out=0 and valid_out=0 the next cycle.
- Priority drain: req_in=4'b1011 for one cycle, ready_in=1 → idx_out sequence 3,1,0 on consecutive cycles. valid_out stays high for exactly 3 cycles and overflow_out stays 0.
- Backpressure: ready_in=0, req_in=4'b0001 then 4'b1000 → idx_out holds 0 with valid_out=1 and pending_out=4'b1000. Raise ready_in → next idx_out=3.
- Overflow/merge: ready_in=0, slot FULL holding idx 2, pending=4'b0001; pulse req_in=4'b0001 → overflow_out=1 for one cycle, pending unchanged. Pulse req_in=4'b0100 → overflow_out=0, pending_out=4'b0101.
- Enable gating: en=0 with req_in=4'b1111 for 5 cycles → pending_out, valid_out and overflow_out stay 0. Existing pending entries still drain when en=0.
